// File: rtl/func_sel_pkg.sv
// Shared constants for the AND/XOR function-select decoder.
package func_sel_pkg;

    // Select encodings of the observed function-select unit
    localparam logic FUNC_AND = 1'b0;
    localparam logic FUNC_XOR = 1'b1;

    // Decoder FSM state encodings
    localparam logic [1:0] IDLE    = 2'd0;
    localparam logic [1:0] COLLECT = 2'd1;
    localparam logic [1:0] REPORT  = 2'd2;

    // Select reported for a pair of surviving-hypothesis flags; only a lone XOR survivor reports XOR
    function automatic logic decodeSelect(input logic andPossible, input logic xorPossible);
        return (xorPossible && !andPossible) ? FUNC_XOR : FUNC_AND;
    endfunction

endpackage

// File: rtl/func_sample_classifier.sv
// Tells whether one observed (op1, op2, out) sample is consistent with AND and/or XOR.
module func_sample_classifier (
    input  logic op1,
    input  logic op2,
    input  logic out,
    output logic andMatch,
    output logic xorMatch
);

    // Compare the observed output against each candidate function
    assign andMatch = (out == (op1 & op2));
    assign xorMatch = (out == (op1 ^ op2));

endmodule

// File: rtl/func_select_decoder.sv
// Recovers the AND/XOR select of a function-select unit from a window of observed samples.
// Optional build macro: FUNC_SELECT_DECODER_EARLY_EXIT_EN -- report a conflict as soon as
// no function can explain the samples seen so far, instead of waiting for the full window.
module func_select_decoder
    import func_sel_pkg::*;
#(
    parameter int unsigned WINDOW = 8,
    parameter int unsigned CNT_W  = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_valid,
    input  logic             i_op1,
    input  logic             i_op2,
    input  logic             i_funcOut,
    output logic             o_ready,
    output logic             o_done,
    output logic             o_funcSelect,
    output logic             o_ambiguous,
    output logic             o_conflict,
    output logic [CNT_W-1:0] o_sampleCount
);

`ifdef FUNC_SELECT_DECODER_EARLY_EXIT_EN
    localparam bit EARLY_EXIT = 1'b1;
`else
    localparam bit EARLY_EXIT = 1'b0;
`endif

    localparam logic [CNT_W-1:0] LAST_COUNT = CNT_W'(WINDOW);

    logic [1:0]       state, stateNext;
    logic [CNT_W-1:0] countNext;
    logic             andPossible, andPossibleNext;
    logic             xorPossible, xorPossibleNext;
    logic             funcSelectNext, ambiguousNext, conflictNext;
    logic             doneNext, readyNext;
    logic             andMatch, xorMatch;
    logic             andUpd, xorUpd, lastSample;
    logic [CNT_W-1:0] countUpd;

    func_sample_classifier uClassifier (
        .op1      (i_op1),
        .op2      (i_op2),
        .out      (i_funcOut),
        .andMatch (andMatch),
        .xorMatch (xorMatch)
    );

    // State, counter, hypothesis flags and all outputs
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state         <= IDLE;
            o_sampleCount <= '0;
            andPossible   <= 1'b1;
            xorPossible   <= 1'b1;
            o_funcSelect  <= 1'b0;
            o_ambiguous   <= 1'b0;
            o_conflict    <= 1'b0;
            o_done        <= 1'b0;
            o_ready       <= 1'b0;
        end else begin
            state         <= stateNext;
            o_sampleCount <= countNext;
            andPossible   <= andPossibleNext;
            xorPossible   <= xorPossibleNext;
            o_funcSelect  <= funcSelectNext;
            o_ambiguous   <= ambiguousNext;
            o_conflict    <= conflictNext;
            o_done        <= doneNext;
            o_ready       <= readyNext;
        end
    end

    // Next-state, flag accumulation and result decision
    always_comb begin
        stateNext       = state;
        countNext       = o_sampleCount;
        andPossibleNext = andPossible;
        xorPossibleNext = xorPossible;
        funcSelectNext  = o_funcSelect;
        ambiguousNext   = o_ambiguous;
        conflictNext    = o_conflict;
        doneNext        = 1'b0;

        andUpd     = andPossible & andMatch;
        xorUpd     = xorPossible & xorMatch;
        countUpd   = o_sampleCount + CNT_W'(1);
        lastSample = (countUpd == LAST_COUNT) || (EARLY_EXIT && !andUpd && !xorUpd);

        if (i_start) begin
            // Start or restart from any state; a sample offered in this cycle is dropped
            stateNext       = COLLECT;
            countNext       = '0;
            andPossibleNext = 1'b1;
            xorPossibleNext = 1'b1;
            funcSelectNext  = 1'b0;
            ambiguousNext   = 1'b0;
            conflictNext    = 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    stateNext = IDLE;
                end
                COLLECT: begin
                    if (i_valid) begin
                        countNext       = countUpd;
                        andPossibleNext = andUpd;
                        xorPossibleNext = xorUpd;
                        if (lastSample) begin
                            stateNext      = REPORT;
                            doneNext       = 1'b1;
                            funcSelectNext = decodeSelect(andUpd, xorUpd);
                            ambiguousNext  = andUpd & xorUpd;
                            conflictNext   = !andUpd && !xorUpd;
                        end
                    end
                end
                REPORT: begin
                    stateNext = IDLE;
                end
                default: begin
                    stateNext = IDLE;
                end
            endcase
        end

        readyNext = (stateNext == COLLECT);
    end

endmodule

// File: tb/tb_func_select_decoder.sv
// Directed scoreboard bench for func_select_decoder (WINDOW=8, CNT_W=4).
`timescale 1ns/1ps
module tb_func_select_decoder;

    logic       i_clk = 1'b0;
    logic       i_rst;
    logic       i_start;
    logic       i_valid;
    logic       i_op1;
    logic       i_op2;
    logic       i_funcOut;
    logic       o_ready;
    logic       o_done;
    logic       o_funcSelect;
    logic       o_ambiguous;
    logic       o_conflict;
    logic [3:0] o_sampleCount;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic sel;
        logic amb;
        logic con;
        int   cnt;
    } exp_t;

    exp_t sb[$];

    func_select_decoder #(.WINDOW(8), .CNT_W(4)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_start       (i_start),
        .i_valid       (i_valid),
        .i_op1         (i_op1),
        .i_op2         (i_op2),
        .i_funcOut     (i_funcOut),
        .o_ready       (o_ready),
        .o_done        (o_done),
        .o_funcSelect  (o_funcSelect),
        .o_ambiguous   (o_ambiguous),
        .o_conflict    (o_conflict),
        .o_sampleCount (o_sampleCount)
    );

    always #5 i_clk = ~i_clk;

    task automatic check1(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic checkAllZero(input string tag);
        check1({tag, "_ready"}, 32'(o_ready), 0);
        check1({tag, "_done"}, 32'(o_done), 0);
        check1({tag, "_sel"}, 32'(o_funcSelect), 0);
        check1({tag, "_amb"}, 32'(o_ambiguous), 0);
        check1({tag, "_con"}, 32'(o_conflict), 0);
        check1({tag, "_cnt"}, 32'(o_sampleCount), 0);
    endtask

    // Inputs change just after a falling edge; the DUT samples them on the next rising edge
    task automatic doStart(input logic v, input logic a, input logic b, input logic c);
        i_start = 1'b1; i_valid = v; i_op1 = a; i_op2 = b; i_funcOut = c;
        @(negedge i_clk);
        i_start = 1'b0; i_valid = 1'b0;
    endtask

    task automatic sample(input logic a, input logic b, input logic c);
        i_valid = 1'b1; i_op1 = a; i_op2 = b; i_funcOut = c;
        @(negedge i_clk);
        i_valid = 1'b0;
    endtask

    task automatic pushExp(input logic sel, input logic amb, input logic con, input int cnt);
        exp_t e;
        e.sel = sel; e.amb = amb; e.con = con; e.cnt = cnt;
        sb.push_back(e);
    endtask

    // Wait (bounded) for o_done, compare against the oldest expectation, then check the pulse ends
    task automatic checkResult(input string tag, input int budget, output int waited);
        exp_t e;
        waited = 0;
        while (!o_done && waited < budget) begin
            @(negedge i_clk);
            waited++;
        end
        check1({tag, "_done"}, 32'(o_done), 1);
        check1({tag, "_sb"}, 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check1({tag, "_sel"}, 32'(o_funcSelect), 32'(e.sel));
            check1({tag, "_amb"}, 32'(o_ambiguous), 32'(e.amb));
            check1({tag, "_con"}, 32'(o_conflict), 32'(e.con));
            check1({tag, "_cnt"}, 32'(o_sampleCount), 32'(e.cnt));
        end
        @(negedge i_clk);
        check1({tag, "_donefall"}, 32'(o_done), 0);
    endtask

    initial begin
        int w;
        i_rst = 1'b1; i_start = 1'b0; i_valid = 1'b0;
        i_op1 = 1'b0; i_op2 = 1'b0; i_funcOut = 1'b0;
        repeat (2) @(negedge i_clk);
        checkAllZero("reset");
        i_rst = 1'b0;
        @(negedge i_clk);

        // 1: all (1,1,1) -> AND, done the cycle after the 8th sample
        pushExp(1'b0, 1'b0, 1'b0, 8);
        doStart(1'b0, 1'b0, 1'b0, 1'b0);
        check1("t1_ready", 32'(o_ready), 1);
        for (int i = 0; i < 8; i++) sample(1'b1, 1'b1, 1'b1);
        checkResult("t1", 20, w);
        check1("t1_latency", 32'(w), 0);
        check1("t1_idle_ready", 32'(o_ready), 0);

        // 2: XOR-only samples with gaps between them
        pushExp(1'b1, 1'b0, 1'b0, 8);
        doStart(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            sample(1'b0, 1'b1, 1'b1);
            @(negedge i_clk);
            sample(1'b1, 1'b1, 1'b0);
            if (i != 3) @(negedge i_clk);
        end
        checkResult("t2", 20, w);
        check1("t2_latency", 32'(w), 0);
        repeat (3) @(negedge i_clk);
        check1("t2_hold_sel", 32'(o_funcSelect), 1);
        check1("t2_hold_cnt", 32'(o_sampleCount), 8);

        // 3: all (0,0,0) -> ambiguous
        pushExp(1'b0, 1'b1, 1'b0, 8);
        doStart(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) sample(1'b0, 1'b0, 1'b0);
        checkResult("t3", 20, w);

        // 4: (1,1,1) then (0,1,1) -> conflict
`ifdef FUNC_SELECT_DECODER_EARLY_EXIT_EN
        pushExp(1'b0, 1'b0, 1'b1, 2);
        doStart(1'b0, 1'b0, 1'b0, 1'b0);
        sample(1'b1, 1'b1, 1'b1);
        sample(1'b0, 1'b1, 1'b1);
        checkResult("t4", 20, w);
        check1("t4_latency", 32'(w), 0);
`else
        pushExp(1'b0, 1'b0, 1'b1, 8);
        doStart(1'b0, 1'b0, 1'b0, 1'b0);
        sample(1'b1, 1'b1, 1'b1);
        sample(1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) sample(1'b0, 1'b0, 1'b0);
        checkResult("t4", 20, w);
        check1("t4_latency", 32'(w), 0);
`endif

        // 5: illegal (0,0,1) result -> conflict
`ifdef FUNC_SELECT_DECODER_EARLY_EXIT_EN
        pushExp(1'b0, 1'b0, 1'b1, 1);
        doStart(1'b0, 1'b0, 1'b0, 1'b0);
        sample(1'b0, 1'b0, 1'b1);
        checkResult("t5", 20, w);
`else
        pushExp(1'b0, 1'b0, 1'b1, 8);
        doStart(1'b0, 1'b0, 1'b0, 1'b0);
        sample(1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 7; i++) sample(1'b1, 1'b1, 1'b1);
        checkResult("t5", 20, w);
`endif

        // 6a: restart after 3 AND-only samples; a sample offered with the restart is dropped
        doStart(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) sample(1'b1, 1'b1, 1'b1);
        check1("t6a_cnt3", 32'(o_sampleCount), 3);
        pushExp(1'b1, 1'b0, 1'b0, 8);
        doStart(1'b1, 1'b1, 1'b1, 1'b1);
        check1("t6a_cnt0", 32'(o_sampleCount), 0);
        for (int i = 0; i < 7; i++) sample(1'b1, 1'b0, 1'b1);
        check1("t6a_nodone7", 32'(o_done), 0);
        check1("t6a_cnt7", 32'(o_sampleCount), 7);
        sample(1'b1, 1'b0, 1'b1);
        checkResult("t6a", 20, w);
        check1("t6a_latency", 32'(w), 0);

        // 6b: asynchronous reset in the middle of a window
        doStart(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) sample(1'b1, 1'b0, 1'b1);
        #2 i_rst = 1'b1;
        #1 checkAllZero("t6b_rst");
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int i = 0; i < 4; i++) sample(1'b1, 1'b1, 1'b1);
        checkAllZero("t6b_ignored");

        // 6c: decoder still works after reset
        pushExp(1'b1, 1'b0, 1'b0, 8);
        doStart(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) sample(1'b1, 1'b1, 1'b0);
        checkResult("t6c", 20, w);

        check1("sb_empty", 32'(sb.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
